// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter and the FIFO instance it
// feeds: arbiter state encoding, default word width and depth, and the width
// helper for the occupancy counter.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Defaults shared with the FIFO instance so both agree on geometry.
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 16;

   // The occupancy counter must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first asserted request at or
// after ptr_i, wrapping cyclically.
//
// Ports:
//   req_i    in   N      request vector
//   ptr_i    in   PW     round-robin start position (0..N-1)
//   valid_o  out  1      at least one request is asserted
//   idx_o    out  PW     index of the chosen requester
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic          valid_o,
   output logic [PW-1:0] idx_o
);

   logic [N-1:0] rot;
   int           pos;

   // Rotate so ptr_i lands at bit 0, take the lowest set bit, rotate back.
   // NOTE: every always_comb output gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      rot     = '0;
      pos     = 0;
      valid_o = 1'b0;
      idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req_i[(i + int'(ptr_i)) % N];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) pos = i;
      end
      valid_o = |rot;
      idx_o   = PW'((pos + int'(ptr_i)) % N);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter letting NUM_REQ producers share one FIFO write port in
// bursts of at most MAX_BURST words. Tracks FIFO occupancy itself (writes from
// W_en, reads from R_en) so it never waits on the FIFO's late Full flag.
// Arbitration takes one IDLE cycle; writes happen only in BURST.
//
// Ports:
//   clk        in   1                 rising-edge clock
//   rst        in   1                 asynchronous active-low reset
//   req        in   NUM_REQ           per-producer word valid
//   req_data   in   NUM_REQ*DATA_W    producer words, slice i = [i*DATA_W +: DATA_W]
//   gnt        out  NUM_REQ           one-hot: producer's word written this cycle
//   W_en       out  1                 FIFO write enable
//   W_data     out  DATA_W            FIFO write data (0 when W_en=0)
//   R_en       in   1                 consumer read strobe (same as to the FIFO)
//   occupancy  out  clog2(DEPTH)+1    words currently held by the FIFO
//   arb_full   out  1                 occupancy == FIFO_DEPTH
//   arb_empty  out  1                 occupancy == 0
//
// Build option: define FIFO_ARB_BURST_RESERVE_EN to grant from IDLE only when
// a full MAX_BURST of free space exists, so granted bursts never stall.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int MAX_BURST  = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*DATA_W-1:0]           req_data,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic                                W_en,
   output logic [DATA_W-1:0]                   W_data,
   input  logic                                R_en,
   output logic [occ_width(FIFO_DEPTH)-1:0]    occupancy,
   output logic                                arb_full,
   output logic                                arb_empty
);

   localparam int OCC_W = occ_width(FIFO_DEPTH);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BCW   = $clog2(MAX_BURST + 1);

   localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(FIFO_DEPTH);
   localparam logic [BCW-1:0]   LAST_BEAT = BCW'(MAX_BURST - 1);
   localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic             space;
   logic             grant_ok;
   logic             rd_eff;
   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;
   logic [PTR_W-1:0] owner_next;

   assign space = (occ_q < DEPTH_C);

`ifdef FIFO_ARB_BURST_RESERVE_EN
   // Free space >= MAX_BURST, rewritten to avoid an unsigned subtraction.
   localparam logic [OCC_W-1:0] RESERVE_LIMIT = OCC_W'(FIFO_DEPTH - MAX_BURST);
   assign grant_ok = (occ_q <= RESERVE_LIMIT);
`else
   assign grant_ok = space;
`endif

   // A read at zero occupancy is ignored so the counter cannot wrap.
   assign rd_eff     = R_en && (occ_q != '0);
   assign owner_next = (owner_q == LAST_REQ) ? '0 : owner_q + PTR_W'(1);

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Next-state and write-port outputs; gnt/W_en/W_data are combinational so a
   // word is written in the same cycle the producer presents it.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      gnt         = '0;
      W_en        = 1'b0;
      W_data      = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid && grant_ok) begin
               owner_d     = pick_idx;
               burst_cnt_d = '0;
               state_d     = BURST;
            end
         end

         BURST: begin
            if (req[owner_q] && space) begin
               gnt[owner_q] = 1'b1;
               W_en         = 1'b1;
               W_data       = req_data[int'(owner_q)*DATA_W +: DATA_W];
               burst_cnt_d  = burst_cnt_q + BCW'(1);
               if (burst_cnt_q == LAST_BEAT) begin
                  state_d  = IDLE;
                  rr_ptr_d = owner_next;
               end
            end else if (!req[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = owner_next;
            end
            // req held with no space: stall, burst_cnt unchanged.
         end

         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (W_en && !rd_eff) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!W_en && rd_eff) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         occ_q       <= occ_d;
      end
   end

   assign occupancy = occ_q;
   assign arb_full  = (occ_q == DEPTH_C);
   assign arb_empty = (occ_q == '0);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8,
// FIFO_DEPTH=16, MAX_BURST=4). Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 unit later, well away from the edge.
// The burst-reserve scenario is compiled only with FIFO_ARB_BURST_RESERVE_EN.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int MB    = 4;
   localparam int OW    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    gnt;
   logic             W_en;
   logic [DW-1:0]    W_data;
   logic             R_en;
   logic [OW-1:0]    occupancy;
   logic             arb_full;
   logic             arb_empty;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .MAX_BURST  (MB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .W_en      (W_en),
      .W_data    (W_data),
      .R_en      (R_en),
      .occupancy (occupancy),
      .arb_full  (arb_full),
      .arb_empty (arb_empty)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic apply_reset();
      rst      = 1'b0;
      req      = '0;
      R_en     = 1'b0;
      req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      req      = '1;
      R_en     = 1'b1;
      req_data = '1;
      repeat (2) @(posedge clk);
      #2;
      n_checks++;
      if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_checks++;
      if (W_en !== 1'b0) begin n_errors++; $display("FAIL reset_w_en: got %b expected 0", W_en); end
      n_checks++;
      if (W_data !== 8'h00) begin n_errors++; $display("FAIL reset_w_data: got %h expected 00", W_data); end
      n_checks++;
      if (occupancy !== 5'd0) begin n_errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      n_checks++;
      if (arb_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", arb_empty); end
      n_checks++;
      if (arb_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", arb_full); end
      req      = '0;
      R_en     = 1'b0;
      req_data = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Producer 1 offers six words, a fresh one after each grant.
   task automatic test_single_burst();
      logic [7:0] exp_mask;
      logic       exp_we;
      int         sent;
      exp_mask = 8'b1101_1110;   // bit c = expected W_en in cycle c
      sent     = 0;
      for (int c = 0; c < 10; c++) begin
         req      = (sent < 6) ? 4'b0010 : 4'b0000;
         req_data = '0;
         req_data[1*DW +: DW] = 8'hA0 + 8'(sent);
         settle();
         exp_we = (c < 8) ? exp_mask[c] : 1'b0;
         n_checks++;
         if (W_en !== exp_we) begin
            n_errors++; $display("FAIL single_w_en c%0d: got %b expected %b", c, W_en, exp_we);
         end
         if (exp_we) begin
            n_checks++;
            if (gnt !== 4'b0010 || W_data !== 8'hA0 + 8'(sent)) begin
               n_errors++;
               $display("FAIL single_word c%0d: got gnt=%b data=%h expected gnt=0010 data=%h",
                        c, gnt, W_data, 8'hA0 + 8'(sent));
            end
            sent++;
         end else begin
            n_checks++;
            if (gnt !== 4'b0000 || W_data !== 8'h00) begin
               n_errors++;
               $display("FAIL single_idle c%0d: got gnt=%b data=%h expected gnt=0000 data=00", c, gnt, W_data);
            end
         end
         cyc();
      end
      settle();
      n_checks++;
      if (occupancy !== 5'd6) begin n_errors++; $display("FAIL single_occ: got %0d expected 6", occupancy); end
      n_checks++;
      if (dut.state_q !== IDLE) begin n_errors++; $display("FAIL single_state: got %b expected IDLE", dut.state_q); end
   endtask

   // All four request continuously; consumer reads from occupancy 2 onward.
   task automatic test_round_robin();
      int         occ_m;
      logic       rd_on;
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      int         we;
      int         rd;
      apply_reset();
      occ_m = 0;
      rd_on = 1'b0;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'(8'h0C + 16 * i);
      req = 4'b1111;
      for (int k = 0; k < 25; k++) begin
         if (occ_m >= 2) rd_on = 1'b1;
         R_en = rd_on;
         settle();
         if (k % 5 == 0) exp_g = 4'b0000;
         else            exp_g = 4'b0001 << ((k / 5) % 4);
         exp_d = (exp_g != 4'b0000) ? 8'(8'h0C + 16 * ((k / 5) % 4)) : 8'h00;
         n_checks++;
         if (gnt !== exp_g) begin n_errors++; $display("FAIL rr_gnt k%0d: got %b expected %b", k, gnt, exp_g); end
         n_checks++;
         if (W_data !== exp_d) begin n_errors++; $display("FAIL rr_data k%0d: got %h expected %h", k, W_data, exp_d); end
         n_checks++;
         if (occupancy !== OW'(occ_m)) begin
            n_errors++; $display("FAIL rr_occ k%0d: got %0d expected %0d", k, occupancy, occ_m);
         end
         we    = (exp_g != 4'b0000) ? 1 : 0;
         rd    = (rd_on && occ_m != 0) ? 1 : 0;
         occ_m = occ_m + we - rd;
         cyc();
      end
      req  = '0;
      R_en = 1'b0;
   endtask

   // Single producer fills the FIFO; one read lets exactly one more word in.
   task automatic test_fill_full();
      int writes;
      apply_reset();
      req = 4'b0001;
      req_data[0 +: DW] = 8'h55;
      for (int k = 0; k < 20; k++) begin
         settle();
         n_checks++;
         if (W_en !== (k % 5 != 0)) begin
            n_errors++; $display("FAIL fill_w_en k%0d: got %b expected %b", k, W_en, (k % 5 != 0));
         end
         cyc();
      end
      for (int k = 0; k < 3; k++) begin
         settle();
         n_checks++;
         if (W_en !== 1'b0 || arb_full !== 1'b1 || occupancy !== 5'd16) begin
            n_errors++;
            $display("FAIL full_hold k%0d: got w_en=%b full=%b occ=%0d expected w_en=0 full=1 occ=16",
                     k, W_en, arb_full, occupancy);
         end
         cyc();
      end
      R_en = 1'b1;
      settle();
      cyc();
      R_en   = 1'b0;
      writes = 0;
      for (int k = 0; k < 8; k++) begin
         settle();
         if (W_en === 1'b1) writes++;
         cyc();
      end
      settle();
      n_checks++;
      if (writes != 1) begin n_errors++; $display("FAIL full_refill_writes: got %0d expected 1", writes); end
      n_checks++;
      if (occupancy !== 5'd16 || arb_full !== 1'b1) begin
         n_errors++; $display("FAIL full_refill_occ: got occ=%0d full=%b expected occ=16 full=1", occupancy, arb_full);
      end
      req = '0;
   endtask

   // Owner 2 drops req after two words; producer 3 must win next even with 0 asking.
   task automatic test_req_drop();
      apply_reset();
      req_data[2*DW +: DW] = 8'h22;
      req_data[3*DW +: DW] = 8'h33;
      req = 4'b1100;
      settle();
      n_checks++;
      if (W_en !== 1'b0) begin n_errors++; $display("FAIL drop_idle: got %b expected 0", W_en); end
      cyc();
      for (int k = 0; k < 2; k++) begin
         settle();
         n_checks++;
         if (gnt !== 4'b0100 || W_data !== 8'h22) begin
            n_errors++; $display("FAIL drop_burst k%0d: got gnt=%b data=%h expected gnt=0100 data=22", k, gnt, W_data);
         end
         cyc();
      end
      req = 4'b1000;
      settle();
      n_checks++;
      if (W_en !== 1'b0) begin n_errors++; $display("FAIL drop_end: got %b expected 0", W_en); end
      cyc();
      req = 4'b1001;
      settle();
      n_checks++;
      if (dut.state_q !== IDLE || dut.rr_ptr_q !== 2'd3) begin
         n_errors++; $display("FAIL drop_ptr: got state=%b rr_ptr=%0d expected state=IDLE rr_ptr=3",
                              dut.state_q, dut.rr_ptr_q);
      end
      cyc();
      settle();
      n_checks++;
      if (gnt !== 4'b1000 || W_data !== 8'h33) begin
         n_errors++; $display("FAIL drop_next: got gnt=%b data=%h expected gnt=1000 data=33", gnt, W_data);
      end
      cyc();
      req = '0;
      cyc();
      cyc();
   endtask

   // Simultaneous write and read at 8; ignored read at 0.
   task automatic test_simultaneous();
      apply_reset();
      req = 4'b0001;
      req_data[0 +: DW] = 8'h77;
      for (int k = 0; k < 11; k++) cyc();
      R_en = 1'b1;
      settle();
      n_checks++;
      if (occupancy !== 5'd8 || W_en !== 1'b1) begin
         n_errors++; $display("FAIL simul_pre: got occ=%0d w_en=%b expected occ=8 w_en=1", occupancy, W_en);
      end
      cyc();
      R_en = 1'b0;
      req  = '0;
      settle();
      n_checks++;
      if (occupancy !== 5'd8) begin n_errors++; $display("FAIL simul_occ: got %0d expected 8", occupancy); end
      cyc();
      apply_reset();
      R_en = 1'b1;
      cyc();
      cyc();
      settle();
      n_checks++;
      if (occupancy !== 5'd0 || arb_empty !== 1'b1 || arb_full !== 1'b0) begin
         n_errors++; $display("FAIL empty_read: got occ=%0d empty=%b full=%b expected occ=0 empty=1 full=0",
                              occupancy, arb_empty, arb_full);
      end
      R_en = 1'b0;
   endtask

   // Asynchronous reset in the middle of a burst, then fresh arbitration.
   task automatic test_reset_mid_burst();
      apply_reset();
      req = 4'b0001;
      req_data[0 +: DW] = 8'h99;
      for (int k = 0; k < 7; k++) cyc();
      settle();
      n_checks++;
      if (occupancy !== 5'd5 || W_en !== 1'b1) begin
         n_errors++; $display("FAIL midrst_pre: got occ=%0d w_en=%b expected occ=5 w_en=1", occupancy, W_en);
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if (W_en !== 1'b0 || gnt !== 4'b0000 || W_data !== 8'h00) begin
         n_errors++; $display("FAIL midrst_outs: got w_en=%b gnt=%b data=%h expected 0 0000 00", W_en, gnt, W_data);
      end
      n_checks++;
      if (occupancy !== 5'd0 || arb_empty !== 1'b1 || arb_full !== 1'b0) begin
         n_errors++; $display("FAIL midrst_occ: got occ=%0d empty=%b full=%b expected 0 1 0", occupancy, arb_empty, arb_full);
      end
      req = 4'b0110;
      req_data[1*DW +: DW] = 8'h11;
      req_data[2*DW +: DW] = 8'h22;
      @(posedge clk);
      #1 rst = 1'b1;
      settle();
      n_checks++;
      if (W_en !== 1'b0) begin n_errors++; $display("FAIL midrst_idle: got %b expected 0", W_en); end
      cyc();
      settle();
      n_checks++;
      if (gnt !== 4'b0010 || W_data !== 8'h11) begin
         n_errors++; $display("FAIL midrst_first: got gnt=%b data=%h expected gnt=0010 data=11", gnt, W_data);
      end
      cyc();
      req = '0;
      cyc();
      cyc();
   endtask

`ifdef FIFO_ARB_BURST_RESERVE_EN
   // Occupancy 13 leaves 3 free words: no grant until a read brings it to 12.
   task automatic test_reserve();
      apply_reset();
      req = 4'b0001;
      req_data[0 +: DW] = 8'h44;
      for (int k = 0; k < 17; k++) cyc();
      req = '0;
      cyc();
      req = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_checks++;
         if (W_en !== 1'b0 || occupancy !== 5'd13 || dut.state_q !== IDLE) begin
            n_errors++; $display("FAIL reserve_hold k%0d: got w_en=%b occ=%0d state=%b expected 0 13 IDLE",
                                 k, W_en, occupancy, dut.state_q);
         end
         cyc();
      end
      R_en = 1'b1;
      settle();
      cyc();
      R_en = 1'b0;
      settle();
      n_checks++;
      if (occupancy !== 5'd12 || W_en !== 1'b0) begin
         n_errors++; $display("FAIL reserve_grant: got occ=%0d w_en=%b expected 12 0", occupancy, W_en);
      end
      cyc();
      settle();
      n_checks++;
      if (W_en !== 1'b1 || gnt !== 4'b0001) begin
         n_errors++; $display("FAIL reserve_write: got w_en=%b gnt=%b expected 1 0001", W_en, gnt);
      end
      req = '0;
      cyc();
      cyc();
   endtask
`endif

   initial begin
      rst      = 1'b0;
      req      = '0;
      R_en     = 1'b0;
      req_data = '0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_fill_full();
      test_req_drop();
      test_simultaneous();
      test_reset_mid_burst();
`ifdef FIFO_ARB_BURST_RESERVE_EN
      test_reserve();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
